// File: rtl/isa_pkg.sv
// Shared ISA constants for the loader and main decoder: opcodes, control words,
// instruction field positions and the loader state encoding.
package isa_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00001;
    localparam logic [4:0] OP_ADDI  = 5'b11000;
    localparam logic [4:0] OP_SUBI  = 5'b11001;
    localparam logic [4:0] OP_LW    = 5'b11010;
    localparam logic [4:0] OP_SW    = 5'b11011;
    localparam logic [4:0] OP_BEQ   = 5'b11100;
    localparam logic [4:0] OP_BNE   = 5'b11101;
    localparam logic [4:0] OP_J     = 5'b00000;
    localparam logic [4:0] OP_JAL   = 5'b00111;

    // {memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump, aluop[1:0]}
    localparam logic [8:0] CTRL_RTYPE = 9'b000011010;
    localparam logic [8:0] CTRL_ADDI  = 9'b000101000;
    localparam logic [8:0] CTRL_SUBI  = 9'b000101011;
    localparam logic [8:0] CTRL_LW    = 9'b100101000;
    localparam logic [8:0] CTRL_SW    = 9'b010100000;
    localparam logic [8:0] CTRL_BEQ   = 9'b001000011;
    localparam logic [8:0] CTRL_BNE   = 9'b000000011;
    localparam logic [8:0] CTRL_JUMP  = 9'b000000100;

    localparam int OP_LSB    = 27;
    localparam int RS_LSB    = 22;
    localparam int RT_LSB    = 17;
    localparam int RD_LSB    = 12;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;
    localparam int TGT_LSB   = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2
    } ld_state_e;

    // Format is implied by the opcode: R-type, jump, or immediate.
    function automatic logic [31:0] pack_word(
        input logic [4:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  funct,
        input logic [16:0] imm,
        input logic [26:0] target
    );
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 5] = op;
        if (op == OP_RTYPE) begin
            w[RS_LSB +: 5]    = rs;
            w[RT_LSB +: 5]    = rt;
            w[RD_LSB +: 5]    = rd;
            w[FUNCT_LSB +: 5] = funct;
        end else if (op == OP_J || op == OP_JAL) begin
            w[TGT_LSB +: 27] = target;
        end else begin
            w[RS_LSB +: 5]   = rs;
            w[RT_LSB +: 5]   = rt;
            w[IMM_LSB +: 17] = imm;
        end
        return w;
    endfunction

endpackage

// File: rtl/ctrl_to_op.sv
// Reverse map from a main-control word to its opcode; also usable to
// cross-check the main decoder.
module ctrl_to_op
    import isa_pkg::*;
(
    input  logic [8:0] ctrl,
    input  logic       link,
    output logic [4:0] op,
    output logic       legal
);

    always_comb begin
        op    = OP_J;
        legal = 1'b1;
        case (ctrl)
            CTRL_RTYPE: op = OP_RTYPE;
            CTRL_ADDI:  op = OP_ADDI;
            CTRL_SUBI:  op = OP_SUBI;
            CTRL_LW:    op = OP_LW;
            CTRL_SW:    op = OP_SW;
            CTRL_BEQ:   op = OP_BEQ;
            CTRL_BNE:   op = OP_BNE;
            CTRL_JUMP:  op = link ? OP_JAL : OP_J;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader: accepts one instruction per handshake, encodes it and writes
// it to instruction memory at a self-incrementing address (IDLE -> ENC -> WR).
module instr_loader
    import isa_pkg::*;
#(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        ctrl,
    input  logic              link,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        funct,
    input  logic [16:0]       imm,
    input  logic [26:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    ld_state_e   state, state_nxt;
    logic [4:0]  op;
    logic        legal;
    logic [31:0] held_word;
    logic        held_legal;
    logic        accept;

    ctrl_to_op u_ctrl_to_op (
        .ctrl  (ctrl),
        .link  (link),
        .op    (op),
        .legal (legal)
    );

    assign in_ready = (state == S_IDLE) && !full && !reset;
    // restart in the same cycle as a valid word takes priority over the accept
    assign accept   = in_valid && in_ready && !restart;
    assign imem_we  = (state == S_WR);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ENC;
            S_ENC:   state_nxt = held_legal ? S_WR : S_IDLE;
            S_WR:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (restart) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            held_word  <= '0;
            held_legal <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                imem_addr <= '0;
                count     <= '0;
                full      <= 1'b0;
                err       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            held_word  <= pack_word(op, rs, rt, rd, funct, imm, target);
                            held_legal <= legal;
                            // flagged on the accept edge so err is visible during ENC
                            if (!legal) err <= 1'b1;
                        end
                    end
                    S_ENC: begin
                        if (held_legal) imem_wdata <= held_word;
                    end
                    S_WR: begin
                        imem_addr <= (imem_addr == ADDR_LAST) ? '0 : imem_addr + 1'b1;
                        count     <= count + 1'b1;
                        if ((count + 1'b1) == DEPTH_C) full <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected writes, a negedge
// monitor pops and checks address, data and write cycle.
module tb_instr_loader;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0, reset = 1'b1, restart = 1'b0, in_valid = 1'b0, link = 1'b0;
    logic [8:0]    ctrl = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0, funct = '0;
    logic [16:0]   imm = '0;
    logic [26:0]   target = '0;
    logic          in_ready, imem_we, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    instr_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .link(link), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
        .target(target), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [AW-1:0] exp_addr = '0;
    int            n_vec = 0, n_bad = 0, we_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_total++;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_we: addr %h data %h at cycle %0d", imem_addr, imem_wdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                chk("wr_data", imem_wdata, mon_e.data);
                chk("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic offer(input logic [8:0] c, input logic lk, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [4:0] f, input logic [16:0] im,
                         input logic [26:0] tg, input bit push, input logic [31:0] w);
        int acc;
        @(negedge clk);
        ctrl = c; link = lk; rs = a; rt = b; rd = d; funct = f; imm = im; target = tg;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
        if (in_ready !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        acc = cyc;
        if (push) begin
            sb.push_back('{exp_addr, w, acc + 2});
            exp_addr = exp_addr + 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  w0;
        bit  seen;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        // ADDI then SW at consecutive addresses
        w0 = we_total;
        offer(9'b000101000, 1'b0, 5'd2, 5'd2, 5'd0, 5'd0, 17'd5, 27'd0, 1'b1, 32'hC0840005);
        offer(9'b010100000, 1'b0, 5'd3, 5'd4, 5'd0, 5'd0, 17'h10, 27'd0, 1'b1, 32'hD8C80010);
        drain();
        @(negedge clk);
        chk("count_two", 32'(count), 2);
        chk("we_pulses_two", we_total - w0, 2);

        // J / JAL fill the remaining two slots
        offer(9'b000000100, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h10, 1'b1, 32'h00000010);
        offer(9'b000000100, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h10, 1'b1, 32'h38000010);
        drain();
        @(negedge clk);
        chk("full_after_4", full, 1);
        chk("count_4", 32'(count), 4);
        chk("in_ready_full", in_ready, 0);
        chk("addr_wrapped", 32'(imem_addr), 0);

        // illegal control word
        do_restart();
        @(negedge clk);
        chk("restart_full", full, 0);
        chk("restart_count", 32'(count), 0);
        w0 = we_total;
        offer(9'b111111111, 1'b0, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1, 1'b0, 32'h0);
        @(negedge clk);
        chk("illegal_err_n1", err, 1);
        chk("illegal_ready_n1", in_ready, 0);
        @(negedge clk);
        chk("illegal_ready_n2", in_ready, 1);
        chk("illegal_addr", 32'(imem_addr), 0);
        chk("illegal_no_we", we_total - w0, 0);
        offer(9'b000011010, 1'b0, 5'd1, 5'd2, 5'd3, 5'd5, 17'd0, 27'd0, 1'b1, 32'h08443005);
        drain();
        @(negedge clk);
        chk("err_sticky", err, 1);
        chk("count_after_rtype", 32'(count), 1);

        // back-to-back fill, fifth word refused
        do_restart();
        w0 = we_total;
        offer(9'b100101000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0, 1'b1, 32'hD0000001);
        offer(9'b000101011, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd2, 27'd0, 1'b1, 32'hC8000002);
        offer(9'b001000011, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd3, 27'd0, 1'b1, 32'hE0000003);
        offer(9'b000000011, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd4, 27'd0, 1'b1, 32'hE8000004);
        ctrl = 9'b000101000; imm = 17'd5;
        in_valid = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (in_ready === 1'b1) seen = 1'b1;
        end
        in_valid = 1'b0;
        chk("fifth_refused", 32'(seen), 0);
        chk("fill_full", full, 1);
        chk("fill_count", 32'(count), 4);
        chk("fill_we_pulses", we_total - w0, 4);
        do_restart();
        @(negedge clk);
        chk("refill_full", full, 0);
        chk("refill_ready", in_ready, 1);
        offer(9'b000101000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd7, 27'd0, 1'b1, 32'hC0000007);
        drain();

        // restart during the WR cycle
        offer(9'b000101000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd9, 27'd0, 1'b1, 32'hC0000009);
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        exp_addr = '0;
        @(negedge clk);
        chk("wr_restart_we", imem_we, 0);
        chk("wr_restart_count", 32'(count), 0);
        chk("wr_restart_addr", 32'(imem_addr), 0);
        chk("wr_restart_sb", sb.size(), 0);

        // restart together with in_valid
        chk("pre_collide_ready", in_ready, 1);
        w0 = we_total;
        ctrl = 9'b000101000; imm = 17'd11;
        in_valid = 1'b1; restart = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; restart = 1'b0;
        repeat (4) @(negedge clk);
        chk("collide_no_we", we_total - w0, 0);
        chk("collide_ready", in_ready, 1);
        chk("collide_count", 32'(count), 0);

        // reset while in ENC
        offer(9'b111111111, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        offer(9'b000101000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 17'hA, 27'd0, 1'b0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("enc_rst_we", imem_we, 0);
        chk("enc_rst_addr", 32'(imem_addr), 0);
        chk("enc_rst_wdata", imem_wdata, 0);
        chk("enc_rst_count", 32'(count), 0);
        chk("enc_rst_full", full, 0);
        chk("enc_rst_err", err, 0);
        chk("enc_rst_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
